// File: rtl/sic_issue_dispatch.sv
// Issue-side dispatcher: buffers typed packets and pulses exactly one matching, requesting sub-SIC slot per cycle.
// Push-to-grant is one edge minimum (no empty bypass); in_ready drops only when the registered FIFO count is full.

module sic_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally modulo DEPTH; clr empties without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

module sic_issue_dispatch #(
  parameter int NUM_SLOTS = 4,
  parameter int PKT_W     = 64,
  parameter int TYPE_W    = 2,
  // Index i holds the execution type of slot i: slot0=0, slot1=0, slot2=1, slot3=2.
  parameter logic [NUM_SLOTS-1:0][TYPE_W-1:0] SLOT_TYPES = {2'd2, 2'd1, 2'd0, 2'd0},
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PKT_W-1:0]           in_pkt,
  input  logic [TYPE_W-1:0]          in_type,
  input  logic                       flush,
  input  logic [NUM_SLOTS-1:0]       slot_req,
  output logic [NUM_SLOTS-1:0]       slot_valid,
  output logic [PKT_W-1:0]           slot_pkt,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err_unroutable
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [PKT_W-1:0]  pkt;
  } entry_t;

  entry_t               push_ent;
  entry_t               head_ent;
  logic                 push;
  logic                 nonempty;
  logic                 routable;
  logic [NUM_SLOTS-1:0] elig;
  logic                 grant_vld;
  logic [SW-1:0]        grant_idx;
  logic [SW-1:0]        rr_ptr;

  assign in_ready = (occupancy < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign push_ent = '{typ: in_type, pkt: in_pkt};
  assign nonempty = (occupancy != '0);

  sic_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (push),
    .push_dat (push_ent),
    .pop      (grant_vld),
    .head_dat (head_ent),
    .count    (occupancy)
  );

  // A slot whose pulse is already high is masked so a stale req can never double-send.
  always_comb begin
    elig     = '0;
    routable = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      elig[i] = nonempty && slot_req[i] && (SLOT_TYPES[i] == head_ent.typ)
                && !slot_valid[i] && !flush;
      if (SLOT_TYPES[i] == head_ent.typ) routable = 1'b1;
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!grant_vld && elig[(int'(rr_ptr) + k) % NUM_SLOTS]) begin
        grant_vld = 1'b1;
        grant_idx = SW'((int'(rr_ptr) + k) % NUM_SLOTS);
      end
    end
  end

  // slot_pkt keeps its last value between grants; receivers qualify it with slot_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid     <= '0;
      slot_pkt       <= '0;
      rr_ptr         <= '0;
      err_unroutable <= 1'b0;
    end else begin
      slot_valid <= '0;
      if (grant_vld) begin
        slot_valid <= NUM_SLOTS'(1) << grant_idx;
        slot_pkt   <= head_ent.pkt;
        rr_ptr     <= (grant_idx == SW'(NUM_SLOTS - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (nonempty && !routable) err_unroutable <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sic_issue_dispatch.sv
// Bench for sic_issue_dispatch: directed scenarios plus a randomized run against a queue-based reference.
module tb_sic_issue_dispatch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pkt = '0;
  logic [1:0]  in_type = '0;
  logic        flush = 1'b0;
  logic [3:0]  slot_req = '0;
  logic [3:0]  slot_valid;
  logic [63:0] slot_pkt;
  logic [2:0]  occupancy;
  logic        err_unroutable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sic_issue_dispatch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pkt         (in_pkt),
    .in_type        (in_type),
    .flush          (flush),
    .slot_req       (slot_req),
    .slot_valid     (slot_valid),
    .slot_pkt       (slot_pkt),
    .occupancy      (occupancy),
    .err_unroutable (err_unroutable)
  );

  // Reference: packet queue plus the observable outputs, advanced once per clock.
  typedef struct { logic [1:0] typ; logic [63:0] pkt; } ent_t;
  ent_t        mq[$];
  int          m_rr;
  logic [3:0]  m_valid;
  logic [63:0] m_pkt;
  logic        m_err;
  int          slot_type[4] = '{0, 0, 1, 2};

  task automatic mreset();
    mq.delete();
    m_rr = 0; m_valid = '0; m_pkt = '0; m_err = 1'b0;
  endtask

  task automatic tick();
    logic [3:0]  nv;
    logic [63:0] np;
    bit          can_push;
    bit          hit;
    int          g;
    nv = '0; np = m_pkt; g = -1;
    can_push = in_valid && (mq.size() < 4) && !flush;
    if (mq.size() > 0) begin
      hit = 0;
      for (int s = 0; s < 4; s++) if (slot_type[s] == int'(mq[0].typ)) hit = 1;
      if (!hit) m_err = 1'b1;
    end
    if (flush) mq.delete();
    else if (mq.size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_rr + k) % 4;
        if (g < 0 && slot_req[i] && slot_type[i] == int'(mq[0].typ) && !m_valid[i]) g = i;
      end
      if (g >= 0) begin
        nv[g] = 1'b1;
        np = mq[0].pkt;
        void'(mq.pop_front());
        m_rr = (g + 1) % 4;
      end
    end
    if (can_push) mq.push_back('{typ: in_type, pkt: in_pkt});
    m_valid = nv; m_pkt = np;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; slot_req = '0; in_pkt = '0; in_type = '0;
    rst_n = 0; #2;
    mreset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    in_valid = 0; flush = 0; slot_req = '0;
    rst_n = 0; #2;
    checks++; if (slot_valid !== 4'b0) begin errors++; $display("FAIL rst_slot_valid got %b exp 0", slot_valid); end
    checks++; if (slot_pkt !== 64'h0) begin errors++; $display("FAIL rst_slot_pkt got %h exp 0", slot_pkt); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy got %0d exp 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (err_unroutable !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_unroutable); end
    mreset();
    @(posedge clk); #1; rst_n = 1;
    slot_req = 4'b0001; in_valid = 1; in_type = 2'd0; in_pkt = 64'hDEAD;
    tick();
    in_valid = 0;
    tick();
    checks++; if (slot_valid !== 4'b0001) begin errors++; $display("FAIL rst_pre_pulse got %b exp 0001", slot_valid); end
    #2 rst_n = 0; #1;
    checks++; if (slot_valid !== 4'b0) begin errors++; $display("FAIL rst_mid_pulse got %b exp 0", slot_valid); end
    checks++; if (slot_pkt !== 64'h0) begin errors++; $display("FAIL rst_mid_pkt got %h exp 0", slot_pkt); end
    mreset();
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_single();
    do_reset();
    slot_req = 4'b0001; in_valid = 1; in_type = 2'd0; in_pkt = 64'hA5;
    tick();
    in_valid = 0;
    checks++; if (slot_valid !== 4'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 0", slot_valid); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ1 got %0d exp 1", occupancy); end
    tick();
    checks++; if (slot_valid !== 4'b0001) begin errors++; $display("FAIL single_valid got %b exp 0001", slot_valid); end
    checks++; if (slot_pkt !== 64'hA5) begin errors++; $display("FAIL single_pkt got %h exp a5", slot_pkt); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_occ0 got %0d exp 0", occupancy); end
    tick();
    checks++; if (slot_valid !== 4'b0) begin errors++; $display("FAIL single_pulse_end got %b exp 0", slot_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    slot_req = 4'b0011; in_type = 2'd0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 4);
      in_pkt = 64'hC0 + 64'(c);
      tick();
      if (c >= 1) begin
        checks++; if (slot_valid !== (4'b0001 << ((c - 1) % 2))) begin errors++; $display("FAIL rr_slot%0d got %b exp %b", c - 1, slot_valid, 4'b0001 << ((c - 1) % 2)); end
        checks++; if (slot_pkt !== 64'hC0 + 64'(c - 1)) begin errors++; $display("FAIL rr_pkt%0d got %h exp %h", c - 1, slot_pkt, 64'hC0 + 64'(c - 1)); end
      end
    end
    in_valid = 0;
    tick();
    checks++; if (slot_valid !== 4'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL rr_drain got %b/%0d exp 0/0", slot_valid, occupancy); end
  endtask

  task automatic test_hol_block();
    do_reset();
    slot_req = 4'b0001;
    in_valid = 1; in_type = 2'd1; in_pkt = 64'h11;
    tick();
    in_type = 2'd0; in_pkt = 64'h22;
    tick();
    in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (slot_valid !== 4'b0 || occupancy !== 3'd2) begin errors++; $display("FAIL hol_blocked got %b/%0d exp 0/2", slot_valid, occupancy); end
    end
    slot_req = 4'b0101;
    tick();
    checks++; if (slot_valid !== 4'b0100 || slot_pkt !== 64'h11) begin errors++; $display("FAIL hol_type1 got %b/%h exp 0100/11", slot_valid, slot_pkt); end
    tick();
    checks++; if (slot_valid !== 4'b0001 || slot_pkt !== 64'h22) begin errors++; $display("FAIL hol_type0 got %b/%h exp 0001/22", slot_valid, slot_pkt); end
  endtask

  task automatic test_full();
    do_reset();
    in_type = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_pkt = 64'h100 + 64'(k);
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", occupancy); end
    in_pkt = 64'h99;
    tick();
    in_valid = 0;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_reject got %0d exp 4", occupancy); end
    slot_req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) begin
        checks++; if (in_ready !== 1'b1 || occupancy !== 3'd3) begin errors++; $display("FAIL full_first_pop got %b/%0d exp 1/3", in_ready, occupancy); end
      end
      checks++; if (slot_valid !== ((c % 2 == 0) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL full_drain_v%0d got %b", c, slot_valid); end
      if (c % 2 == 0) begin
        checks++; if (slot_pkt !== 64'h100 + 64'(c / 2)) begin errors++; $display("FAIL full_drain_p%0d got %h exp %h", c, slot_pkt, 64'h100 + 64'(c / 2)); end
      end
    end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", occupancy); end
  endtask

  task automatic test_flush();
    do_reset();
    in_type = 2'd0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_pkt = 64'h200 + 64'(k);
      tick();
    end
    in_pkt = 64'h77; flush = 1; slot_req = 4'b1111;
    tick();
    flush = 0; in_valid = 0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    checks++; if (slot_valid !== 4'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", slot_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (slot_valid !== 4'b0) begin errors++; $display("FAIL flush_after got %b exp 0", slot_valid); end
    end
  endtask

  task automatic test_unroutable();
    do_reset();
    slot_req = 4'b1111; in_valid = 1; in_type = 2'd3; in_pkt = 64'h33;
    tick();
    in_valid = 0;
    checks++; if (err_unroutable !== 1'b0) begin errors++; $display("FAIL unr_early got %b exp 0", err_unroutable); end
    tick();
    checks++; if (err_unroutable !== 1'b1 || occupancy !== 3'd1 || slot_valid !== 4'b0) begin errors++; $display("FAIL unr_set got %b/%0d/%b exp 1/1/0", err_unroutable, occupancy, slot_valid); end
    flush = 1;
    tick();
    flush = 0;
    checks++; if (err_unroutable !== 1'b1 || occupancy !== 3'd0) begin errors++; $display("FAIL unr_flush got %b/%0d exp 1/0", err_unroutable, occupancy); end
    tick();
    checks++; if (err_unroutable !== 1'b1) begin errors++; $display("FAIL unr_sticky got %b exp 1", err_unroutable); end
    rst_n = 0; #2;
    checks++; if (err_unroutable !== 1'b0) begin errors++; $display("FAIL unr_reset got %b exp 0", err_unroutable); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_type  = ($urandom_range(0, 63) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_pkt   = {$urandom(), $urandom()};
      flush    = ($urandom_range(0, 23) == 0);
      slot_req = 4'($urandom());
      tick();
      checks++; if (slot_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, slot_valid, m_valid); end
      checks++; if (slot_pkt !== m_pkt) begin errors++; $display("FAIL rnd_pkt c%0d got %h exp %h", c, slot_pkt, m_pkt); end
      checks++; if (occupancy !== 3'(mq.size())) begin errors++; $display("FAIL rnd_occ c%0d got %0d exp %0d", c, occupancy, mq.size()); end
      checks++; if (in_ready !== (mq.size() < 4)) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, in_ready, mq.size() < 4); end
      checks++; if (err_unroutable !== m_err) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", c, err_unroutable, m_err); end
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    mreset();
    test_reset();
    test_single();
    test_round_robin();
    test_hol_block();
    test_full();
    test_flush();
    test_unroutable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
